bf_mul_accumulator: RTL and testbench



---
 rtl/bf_pkg.sv | 44 ++++
 rtl/bf_align_add.sv | 103 ++++++++++
 rtl/bf_mul_accumulator.sv | 120 ++++++++++++
 tb/tb_bf_mul_accumulator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared types and constants for the {exp, frac} accumulator: word layout,
// exponent limits, FSM states and pack/unpack helpers.
package bf_pkg;

  localparam int unsigned EXP_W  = 9;
  localparam int unsigned FRAC_W = 7;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WORD_W = EXP_W + FRAC_W;

  localparam logic signed [EXP_W-1:0] EXP_MAX = EXP_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EXP_W-1:0] EXP_MIN = EXP_W'(1 << (EXP_W - 1));

  localparam logic [WORD_W-1:0] ZERO = WORD_W'(0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_OUT
  } state_e;

  typedef struct packed {
    logic signed [EXP_W-1:0] expn;
    logic [FRAC_W-1:0]       frac;
  } bf_t;

  function automatic logic [WORD_W-1:0] bf_pack(input bf_t v);
    return v;
  endfunction

  function automatic bf_t bf_unpack(input logic [WORD_W-1:0] w);
    return bf_t'(w);
  endfunction

  function automatic bf_t bf_make(input logic signed [EXP_W-1:0] expn,
                                  input logic [FRAC_W-1:0] frac);
    bf_t v;
    v.expn = expn;
    v.frac = frac;
    return v;
  endfunction

endpackage

// File: rtl/bf_align_add.sv
// Operand registers plus the one-bit-per-cycle align, add and normalise steps.
// The controlling FSM strobes exactly one of load/align/add/norm per cycle.
module bf_align_add
  import bf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic align_i,
  input  logic add_i,
  input  logic norm_i,
  input  bf_t  acc_i,
  input  bf_t  term_i,
  output logic zero_op_c_o,
  output logic align_done_c_o,
  output logic norm_done_c_o,
  output logic ovf_c_o,
  output bf_t  res_c_o
);

  localparam logic signed [EXP_W:0] LIM_POS = (EXP_W + 1)'(FRAC_W + 1);
  localparam logic signed [EXP_W:0] LIM_NEG = -LIM_POS;
  localparam logic signed [EXP_W:0] ONE_POS = (EXP_W + 1)'(1);
  localparam logic signed [EXP_W:0] ONE_NEG = -ONE_POS;

  logic signed [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [FRAC_W-1:0]       fa_q, fa_d, fb_q, fb_d;
  logic signed [EXP_W:0]   diff_c;
  logic [FRAC_W:0]         sum_c;

  // Exponent difference needs one extra bit so -256 - 255 cannot wrap.
  assign diff_c = {ea_q[EXP_W-1], ea_q} - {eb_q[EXP_W-1], eb_q};
  assign sum_c  = {1'b0, fa_q} + {1'b0, fb_q};

  assign zero_op_c_o    = (fa_q == '0) || (fb_q == '0);
  assign align_done_c_o = (diff_c >= LIM_POS) || (diff_c <= LIM_NEG) ||
                          ((diff_c >= ONE_NEG) && (diff_c <= ONE_POS));
  assign norm_done_c_o  = (fa_q == '0) || fa_q[FRAC_W-1] || (ea_q == EXP_MIN);
  assign ovf_c_o        = add_i && sum_c[FRAC_W] && (ea_q == EXP_MAX);
  assign res_c_o        = (fa_q == '0) ? bf_unpack(ZERO) : bf_make(ea_q, fa_q);

  always_comb begin
    ea_d = ea_q;
    fa_d = fa_q;
    eb_d = eb_q;
    fb_d = fb_q;
    if (load_i) begin
      ea_d = acc_i.expn;
      fa_d = acc_i.frac;
      eb_d = term_i.expn;
      fb_d = term_i.frac;
    end else if (align_i) begin
      // A zero operand short-circuits: the other one becomes the sum in place.
      if (fa_q == '0) begin
        ea_d = eb_q;
        fa_d = fb_q;
      end else if (fb_q != '0) begin
        if (diff_c >= LIM_POS) begin
          eb_d = ea_q;
          fb_d = '0;
        end else if (diff_c <= LIM_NEG) begin
          ea_d = eb_q;
          fa_d = '0;
        end else if (!diff_c[EXP_W] && (diff_c != '0)) begin
          eb_d = eb_q + 9'sd1;
          fb_d = fb_q >> 1;
        end else if (diff_c[EXP_W]) begin
          ea_d = ea_q + 9'sd1;
          fa_d = fa_q >> 1;
        end
      end
    end else if (add_i) begin
      if (sum_c[FRAC_W]) begin
        if (ea_q == EXP_MAX) begin
          fa_d = '1;
        end else begin
          fa_d = sum_c[FRAC_W:1];
          ea_d = ea_q + 9'sd1;
        end
      end else begin
        fa_d = sum_c[FRAC_W-1:0];
      end
    end else if (norm_i && !norm_done_c_o) begin
      fa_d = fa_q << 1;
      ea_d = ea_q - 9'sd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ea_q <= '0;
      fa_q <= '0;
      eb_q <= '0;
      fb_q <= '0;
    end else begin
      ea_q <= ea_d;
      fa_q <= fa_d;
      eb_q <= eb_d;
      fb_q <= fb_d;
    end
  end

endmodule

// File: rtl/bf_mul_accumulator.sv
// Group accumulator for {exp, frac} product words: valid/ready in, one result
// per group out, with sticky exponent-saturation flag and saturating term count.
module bf_mul_accumulator
  import bf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_ovf_o,
  output logic [CNT_W-1:0]  out_count_o
);

  state_e           state_q, state_d;
  bf_t              acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, out_valid_q;

  logic load_c, align_c, add_c, norm_c;
  logic zero_op_c, align_done_c, norm_done_c, ovf_c;
  bf_t  res_c;

  bf_align_add u_dp (
    .clk            (clk),
    .rst            (rst),
    .load_i         (load_c),
    .align_i        (align_c),
    .add_i          (add_c),
    .norm_i         (norm_c),
    .acc_i          (acc_q),
    .term_i         (bf_unpack(in_data_i)),
    .zero_op_c_o    (zero_op_c),
    .align_done_c_o (align_done_c),
    .norm_done_c_o  (norm_done_c),
    .ovf_c_o        (ovf_c),
    .res_c_o        (res_c)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    align_c = 1'b0;
    add_c   = 1'b0;
    norm_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          load_c  = 1'b1;
          last_d  = in_last_i;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        align_c = 1'b1;
        if (zero_op_c)         state_d = S_NORM;
        else if (align_done_c) state_d = S_ADD;
      end
      S_ADD: begin
        add_c   = 1'b1;
        ovf_d   = ovf_q | ovf_c;
        state_d = S_NORM;
      end
      S_NORM: begin
        norm_c = 1'b1;
        if (norm_done_c) begin
          acc_d   = res_c;
          state_d = last_q ? S_OUT : S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          acc_d   = bf_unpack(ZERO);
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= bf_unpack(ZERO);
      ovf_q       <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_OUT);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = bf_pack(acc_q);
  assign out_ovf_o   = ovf_q;
  assign out_count_o = cnt_q;

endmodule

// File: tb/tb_bf_mul_accumulator.sv
// Randomised self-checking bench for bf_mul_accumulator against a value-level
// reference model of the group sum.
module tb_bf_mul_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic [7:0]  out_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_acc;
  bit          m_ovf;
  int          m_cnt;

  bf_mul_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ovf_o   (out_ovf),
    .out_count_o (out_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    m_acc = 16'h0000;
    m_ovf = 1'b0;
    m_cnt = 0;
  endfunction

  // Value-level sum: align by truncating the smaller operand, add, renormalise.
  function automatic void model_term(input logic [15:0] t);
    int ea, eb, fa, fb, e, f, d;
    ea = int'($signed(m_acc[15:7]));
    fa = int'(m_acc[6:0]);
    eb = int'($signed(t[15:7]));
    fb = int'(t[6:0]);
    if (fa == 0) begin
      e = eb; f = fb;
    end else if (fb == 0) begin
      e = ea; f = fa;
    end else begin
      if (ea >= eb) begin
        d = ea - eb; e = ea; f = fa + ((d >= 8) ? 0 : (fb >> d));
      end else begin
        d = eb - ea; e = eb; f = fb + ((d >= 8) ? 0 : (fa >> d));
      end
      if (f >= 128) begin
        if (e == 255) begin
          f = 127; m_ovf = 1'b1;
        end else begin
          f = f / 2; e = e + 1;
        end
      end
    end
    while (f != 0 && f < 64 && e > -256) begin
      f = f * 2; e = e - 1;
    end
    m_acc = (f == 0) ? 16'h0000 : {9'(e), 7'(f)};
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endfunction

  function automatic logic [15:0] rand_term();
    logic [8:0] e;
    logic [6:0] f;
    case ($urandom_range(0, 5))
      0, 1, 2: e = 9'($urandom_range(0, 10)) - 9'd5;
      3:       e = 9'($urandom);
      4:       e = 9'd255 - 9'($urandom_range(0, 3));
      default: e = 9'h100 + 9'($urandom_range(0, 3));
    endcase
    f = 7'($urandom);
    if ($urandom_range(0, 7) == 0) f = 7'h00;
    return {e, f};
  endfunction

  task automatic send_term(input logic [15:0] w, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      in_data  = w;
      in_last  = l;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      model_term(w);
    end
  endtask

  task automatic expect_result(input logic [15:0] d, input bit o, input int c, input int stall);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("out_valid_seen", 32'(out_valid), 32'd1);
    check_eq("out_data", 32'(out_data), 32'(d));
    check_eq("out_ovf", 32'(out_ovf), 32'(o));
    check_eq("out_count", 32'(out_count), 32'(c));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check_eq("stall_data", 32'(out_data), 32'(d));
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("valid_drop", 32'(out_valid), 32'd0);
    check_eq("count_clear", 32'(out_count), 32'd0);
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
    check_eq("rst_out_count", 32'(out_count), 32'd0);

    send_term(16'h0040, 1'b0); send_term(16'h0040, 1'b1);
    expect_result(16'h00C0, 1'b0, 2, 0);
    send_term(16'h0040, 1'b0); send_term(16'hFFC0, 1'b1);
    expect_result(16'h0060, 1'b0, 2, 0);
    send_term(16'h0040, 1'b0); send_term(16'hFB40, 1'b1);
    expect_result(16'h0040, 1'b0, 2, 0);
    send_term(16'h7FC0, 1'b0); send_term(16'h7FC0, 1'b1);
    expect_result(16'h7FFF, 1'b1, 2, 0);
    send_term(16'h0000, 1'b1);
    expect_result(16'h0000, 1'b0, 1, 0);
    // 0.25 normalises to frac 0x40 at exp -2.
    send_term(16'h0010, 1'b1);
    expect_result(16'hFF40, 1'b0, 1, 0);
    send_term(16'h0040, 1'b0); send_term(16'h0040, 1'b1);
    expect_result(16'h00C0, 1'b0, 2, 10);

    send_term(16'h0040, 1'b0);
    send_term(16'h0040, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_count", 32'(out_count), 32'd0);
    check_eq("midrst_data", 32'(out_data), 32'd0);

    for (int i = 0; i < 260; i++) send_term({9'($urandom), 7'h00}, i == 259);
    expect_result(16'h0000, 1'b0, 255, 0);

    for (int g = 0; g < 60; g++) begin
      int nt;
      nt = int'($urandom_range(1, 6));
      for (int t = 0; t < nt; t++) send_term(rand_term(), t == nt - 1);
      expect_result(m_acc, m_ovf, m_cnt, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
